// File: rtl/conv_array_ctrl.sv
// conv_array_ctrl: frame sequencer for the convolution unit array.
// Walks the image row-major, streams each pixel to the unit that owns the
// current row (rows dealt round-robin), arbitrates unit results onto one
// output port, and pulses done once every unit has gone idle.
module conv_array_ctrl #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 10,
  parameter int NUM_CAU = 4,
  parameter int IMG_N   = 16,
  parameter int IMG_M   = 16
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        start,
  input  logic [1:0]                                  opcode,
  output logic                                        busy,
  output logic                                        done,
  output logic [ADDR_W-1:0]                           mem_addr,
  output logic                                        mem_rd_en,
  input  logic [DATA_W-1:0]                           mem_rd_data,
  output logic [NUM_CAU-1:0]                          cau_sel,
  output logic [1:0]                                  cau_opcode,
  output logic [DATA_W-1:0]                           cau_data,
  output logic                                        cau_valid,
  input  logic [NUM_CAU-1:0]                          cau_ready,
  input  logic [NUM_CAU-1:0]                          cau_busy,
  input  logic [NUM_CAU-1:0]                          cau_res_valid,
  input  logic [NUM_CAU*DATA_W-1:0]                   cau_res_data,
  output logic [NUM_CAU-1:0]                          cau_res_ack,
  output logic                                        out_valid,
  output logic [DATA_W-1:0]                           out_data,
  output logic [(NUM_CAU > 1 ? $clog2(NUM_CAU) : 1)-1:0] out_cau_id
);

  localparam int RW = (IMG_N > 1) ? $clog2(IMG_N) : 1;
  localparam int CW = (IMG_M > 1) ? $clog2(IMG_M) : 1;
  localparam int PW = (NUM_CAU > 1) ? $clog2(NUM_CAU) : 1;

  typedef enum logic [1:0] {IDLE, FETCH, SEND, DRAIN} state_t;

  state_t            state_reg, state_next;
  logic [RW-1:0]     row_reg;
  logic [CW-1:0]     col_reg;
  logic [PW-1:0]     ptr_reg;
  logic [1:0]        opcode_reg;
  logic [NUM_CAU-1:0] sel_onehot;
  logic [DATA_W-1:0] res_arr [NUM_CAU];
  logic              start_frame, xfer;
  logic              col_last, pix_last;
  logic [NUM_CAU-1:0] grant;
  logic [PW-1:0]     grant_idx;
  logic [DATA_W-1:0] grant_data;

  // Unpack per-unit result buses and decode the unit pointer to one-hot.
  for (genvar gi = 0; gi < NUM_CAU; gi++) begin : g_unit
    assign res_arr[gi]    = cau_res_data[gi*DATA_W +: DATA_W];
    assign sel_onehot[gi] = (ptr_reg == PW'(gi));
  end

  assign col_last   = (col_reg == CW'(IMG_M - 1));
  assign pix_last   = col_last && (row_reg == RW'(IMG_N - 1));
  assign busy       = (state_reg != IDLE);
  assign cau_opcode = opcode_reg;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next state and per-state outputs; the pixel stays on the bus until accepted.
  always_comb begin
    state_next  = state_reg;
    start_frame = 1'b0;
    xfer        = 1'b0;
    done        = 1'b0;
    mem_rd_en   = 1'b0;
    mem_addr    = '0;
    cau_valid   = 1'b0;
    cau_data    = '0;
    cau_sel     = '0;
    case (state_reg)
      IDLE: begin
        if (start && (opcode != 2'b00)) begin
          start_frame = 1'b1;
          state_next  = FETCH;
        end
      end
      FETCH: begin
        mem_rd_en  = 1'b1;
        mem_addr   = ADDR_W'(row_reg) * ADDR_W'(IMG_M) + ADDR_W'(col_reg);
        state_next = SEND;
      end
      SEND: begin
        cau_valid = 1'b1;
        cau_data  = mem_rd_data;
        cau_sel   = sel_onehot;
        if ((cau_ready & sel_onehot) != '0) begin
          xfer       = 1'b1;
          state_next = pix_last ? DRAIN : FETCH;
        end
      end
      DRAIN: begin
        if ((cau_busy == '0) && (cau_res_valid == '0)) begin
          done       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Row/column/unit pointer walk and frame opcode latch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_reg    <= '0;
      col_reg    <= '0;
      ptr_reg    <= '0;
      opcode_reg <= 2'b00;
    end else if (start_frame) begin
      row_reg    <= '0;
      col_reg    <= '0;
      ptr_reg    <= '0;
      opcode_reg <= opcode;
    end else if (xfer) begin
      if (col_last) begin
        col_reg <= '0;
        row_reg <= pix_last ? '0 : row_reg + RW'(1);
        ptr_reg <= (ptr_reg == PW'(NUM_CAU - 1)) ? '0 : ptr_reg + PW'(1);
      end else begin
        col_reg <= col_reg + CW'(1);
      end
    end
  end

  // Fixed-priority grant: scan downward so the lowest pending index wins.
  always_comb begin
    grant      = '0;
    grant_idx  = '0;
    grant_data = '0;
    for (int i = NUM_CAU - 1; i >= 0; i--) begin
      if (cau_res_valid[i]) begin
        grant      = '0;
        grant[i]   = 1'b1;
        grant_idx  = PW'(i);
        grant_data = res_arr[i];
      end
    end
  end

  assign cau_res_ack = grant;

  // Registered result port; data/id hold their last value between results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_cau_id <= '0;
    end else begin
      out_valid <= (cau_res_valid != '0);
      if (cau_res_valid != '0) begin
        out_data   <= grant_data;
        out_cau_id <= grant_idx;
      end
    end
  end

endmodule

// File: tb/tb_conv_array_ctrl.sv
// Directed bench for conv_array_ctrl: a 4x4 image over 4 units, plus a
// second instance with 3 units and 5 rows for round-robin wrap.
module tb_conv_array_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  // Main instance signals
  logic        start;
  logic [1:0]  opcode;
  logic        busy, done;
  logic [9:0]  mem_addr;
  logic        mem_rd_en;
  logic [7:0]  mem_rd_data;
  logic [3:0]  cau_sel;
  logic [1:0]  cau_opcode;
  logic [7:0]  cau_data;
  logic        cau_valid;
  logic [3:0]  cau_ready, cau_busy, cau_res_valid, cau_res_ack;
  logic [31:0] cau_res_data;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_cau_id;

  // Second instance signals
  logic        start2;
  logic [1:0]  opcode2;
  logic        busy2, done2;
  logic [9:0]  mem_addr2;
  logic        mem_rd_en2;
  logic [7:0]  mem_rd_data2;
  logic [2:0]  cau_sel2;
  logic [1:0]  cau_opcode2;
  logic [7:0]  cau_data2;
  logic        cau_valid2;
  logic [2:0]  cau_ready2, cau_busy2, cau_res_valid2, cau_res_ack2;
  logic [23:0] cau_res_data2;
  logic        out_valid2;
  logic [7:0]  out_data2;
  logic [1:0]  out_cau_id2;

  conv_array_ctrl #(.DATA_W(8), .ADDR_W(10), .NUM_CAU(4), .IMG_N(4), .IMG_M(4)) dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode), .busy(busy), .done(done),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rd_data(mem_rd_data),
    .cau_sel(cau_sel), .cau_opcode(cau_opcode), .cau_data(cau_data), .cau_valid(cau_valid),
    .cau_ready(cau_ready), .cau_busy(cau_busy), .cau_res_valid(cau_res_valid),
    .cau_res_data(cau_res_data), .cau_res_ack(cau_res_ack), .out_valid(out_valid),
    .out_data(out_data), .out_cau_id(out_cau_id)
  );

  conv_array_ctrl #(.DATA_W(8), .ADDR_W(10), .NUM_CAU(3), .IMG_N(5), .IMG_M(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .opcode(opcode2), .busy(busy2), .done(done2),
    .mem_addr(mem_addr2), .mem_rd_en(mem_rd_en2), .mem_rd_data(mem_rd_data2),
    .cau_sel(cau_sel2), .cau_opcode(cau_opcode2), .cau_data(cau_data2), .cau_valid(cau_valid2),
    .cau_ready(cau_ready2), .cau_busy(cau_busy2), .cau_res_valid(cau_res_valid2),
    .cau_res_data(cau_res_data2), .cau_res_ack(cau_res_ack2), .out_valid(out_valid2),
    .out_data(out_data2), .out_cau_id(out_cau_id2)
  );

  // Synchronous memory models: mem[i] = i, data held until the next read.
  always @(posedge clk) begin
    if (mem_rd_en)  mem_rd_data  <= mem_addr[7:0];
    if (mem_rd_en2) mem_rd_data2 <= mem_addr2[7:0];
  end

  // Transfer / done counters and the second instance's per-transfer unit log.
  int xfer_count = 0;
  int done_count = 0;
  int xfer2 = 0;
  logic [2:0] sel_log2 [10];
  always @(posedge clk) begin
    if (cau_valid && ((cau_ready & cau_sel) != 4'b0000)) xfer_count++;
    if (done) done_count++;
    if (cau_valid2 && ((cau_ready2 & cau_sel2) != 3'b000)) begin
      if (xfer2 < 10) sel_log2[xfer2] = cau_sel2;
      xfer2++;
    end
  end

  task automatic test_reset;
    repeat (2) @(negedge clk);
    #1;
    nvec++;
    if ({busy, done, mem_rd_en, cau_valid, out_valid} !== 5'b00000) begin
      nerr++; $display("FAIL reset_flags got %b want 00000", {busy, done, mem_rd_en, cau_valid, out_valid});
    end
    nvec++;
    if ({mem_addr, cau_sel, cau_opcode, cau_res_ack} !== 20'h0) begin
      nerr++; $display("FAIL reset_bus got addr=%h sel=%b op=%b ack=%b want all zero", mem_addr, cau_sel, cau_opcode, cau_res_ack);
    end
    nvec++;
    if ({out_data, out_cau_id} !== 10'h0) begin
      nerr++; $display("FAIL reset_out got data=%h id=%0d want 0/0", out_data, out_cau_id);
    end
    $display("reset: outputs checked");
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_three_units;
    logic [2:0] es;
    bit seen;
    seen = 1'b0;
    @(negedge clk);
    start2 = 1'b1; opcode2 = 2'b01;
    @(negedge clk);
    start2 = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (done2) begin seen = 1'b1; break; end
    end
    nvec++;
    if (!seen) begin nerr++; $display("FAIL three_done got no done want done pulse"); end
    nvec++;
    if (xfer2 !== 10) begin nerr++; $display("FAIL three_xfers got %0d want 10", xfer2); end
    for (int i = 0; i < 10; i++) begin
      es = 3'b001 << ((i / 2) % 3);
      nvec++;
      if (sel_log2[i] !== es) begin
        nerr++; $display("FAIL three_sel pixel %0d got %b want %b", i, sel_log2[i], es);
      end
      $display("three_units: pixel %0d sel %b", i, sel_log2[i]);
    end
  endtask

  task automatic test_frame;
    int x0, d0;
    logic [3:0] es;
    x0 = xfer_count; d0 = done_count;
    @(negedge clk);
    cau_busy = 4'b0001; start = 1'b1; opcode = 2'b01;
    #1;
    nvec++;
    if (busy !== 1'b0) begin nerr++; $display("FAIL frame_idle_busy got %b want 0", busy); end
    for (int p = 0; p < 16; p++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      nvec++;
      if ({mem_rd_en, mem_addr} !== {1'b1, 10'(p)}) begin
        nerr++; $display("FAIL frame_fetch p=%0d got en=%b addr=%0d want 1/%0d", p, mem_rd_en, mem_addr, p);
      end
      if (p == 0) begin
        nvec++;
        if ({busy, cau_opcode} !== 3'b101) begin
          nerr++; $display("FAIL frame_first got busy=%b op=%b want 1/01", busy, cau_opcode);
        end
      end
      @(negedge clk); #1;
      es = 4'b0001 << (p / 4);
      nvec++;
      if ({cau_valid, cau_sel, cau_data} !== {1'b1, es, 8'(p)}) begin
        nerr++; $display("FAIL frame_send p=%0d got v=%b sel=%b data=%0d want 1/%b/%0d", p, cau_valid, cau_sel, cau_data, es, p);
      end
      $display("frame: pixel %0d sel %b data %0d", p, cau_sel, cau_data);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      nvec++;
      if ({busy, done, cau_valid, mem_rd_en} !== 4'b1000) begin
        nerr++; $display("FAIL frame_drain_wait got %b want 1000", {busy, done, cau_valid, mem_rd_en});
      end
    end
    cau_busy = 4'b0000;
    #1;
    nvec++;
    if (done !== 1'b1) begin nerr++; $display("FAIL frame_done got %b want 1", done); end
    @(negedge clk); #1;
    nvec++;
    if ({busy, done} !== 2'b00) begin nerr++; $display("FAIL frame_after got %b want 00", {busy, done}); end
    nvec++;
    if (xfer_count - x0 !== 16) begin nerr++; $display("FAIL frame_xfers got %0d want 16", xfer_count - x0); end
    nvec++;
    if (done_count - d0 !== 1) begin nerr++; $display("FAIL frame_done_count got %0d want 1", done_count - d0); end
  endtask

  task automatic test_stall_and_restart;
    int x0, d0;
    logic [3:0] es;
    x0 = xfer_count; d0 = done_count;
    @(negedge clk);
    start = 1'b1; opcode = 2'b01;
    for (int p = 0; p < 16; p++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      nvec++;
      if ({mem_rd_en, mem_addr} !== {1'b1, 10'(p)}) begin
        nerr++; $display("FAIL stall_fetch p=%0d got en=%b addr=%0d", p, mem_rd_en, mem_addr);
      end
      if (p == 4) cau_ready = 4'b1101;
      es = 4'b0001 << (p / 4);
      for (int k = 0; k < ((p == 4) ? 5 : 1); k++) begin
        @(negedge clk); #1;
        nvec++;
        if ({cau_valid, cau_sel, cau_data} !== {1'b1, es, 8'(p)}) begin
          nerr++; $display("FAIL stall_send p=%0d cyc=%0d got v=%b sel=%b data=%0d want 1/%b/%0d", p, k, cau_valid, cau_sel, cau_data, es, p);
        end
        $display("stall: pixel %0d cycle %0d sel %b data %0d", p, k, cau_sel, cau_data);
      end
      cau_ready = 4'b1111;
    end
    @(negedge clk); #1;
    nvec++;
    if (done !== 1'b1) begin nerr++; $display("FAIL stall_done got %b want 1", done); end
    start = 1'b1; opcode = 2'b01;
    @(negedge clk); #1;
    nvec++;
    if ({busy, mem_rd_en} !== 2'b00) begin
      nerr++; $display("FAIL start_in_done got busy=%b en=%b want 0/0", busy, mem_rd_en);
    end
    @(negedge clk);
    start = 1'b0;
    #1;
    nvec++;
    if ({busy, mem_rd_en, mem_addr} !== {2'b11, 10'd0}) begin
      nerr++; $display("FAIL start_after_done got busy=%b en=%b addr=%0d want 1/1/0", busy, mem_rd_en, mem_addr);
    end
    nvec++;
    if (xfer_count - x0 !== 16) begin nerr++; $display("FAIL stall_xfers got %0d want 16", xfer_count - x0); end
    nvec++;
    if (done_count - d0 !== 1) begin nerr++; $display("FAIL stall_done_count got %0d want 1", done_count - d0); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_arbiter;
    cau_res_data = {8'hBB, 8'h22, 8'hAA, 8'h11};
    @(negedge clk);
    cau_res_valid = 4'b1010;
    #1;
    nvec++;
    if ({cau_res_ack, out_valid} !== 5'b00100) begin
      nerr++; $display("FAIL arb_grant1 got ack=%b ov=%b want 0010/0", cau_res_ack, out_valid);
    end
    @(negedge clk);
    cau_res_valid = 4'b1000;
    #1;
    nvec++;
    if ({out_valid, out_data, out_cau_id} !== {1'b1, 8'hAA, 2'd1}) begin
      nerr++; $display("FAIL arb_out1 got v=%b data=%h id=%0d want 1/aa/1", out_valid, out_data, out_cau_id);
    end
    $display("arbiter: out %h id %0d", out_data, out_cau_id);
    nvec++;
    if (cau_res_ack !== 4'b1000) begin nerr++; $display("FAIL arb_grant2 got %b want 1000", cau_res_ack); end
    @(negedge clk);
    cau_res_valid = 4'b0000;
    #1;
    nvec++;
    if ({out_valid, out_data, out_cau_id} !== {1'b1, 8'hBB, 2'd3}) begin
      nerr++; $display("FAIL arb_out2 got v=%b data=%h id=%0d want 1/bb/3", out_valid, out_data, out_cau_id);
    end
    $display("arbiter: out %h id %0d", out_data, out_cau_id);
    nvec++;
    if (cau_res_ack !== 4'b0000) begin nerr++; $display("FAIL arb_idle_ack got %b want 0000", cau_res_ack); end
    @(negedge clk); #1;
    nvec++;
    if (out_valid !== 1'b0) begin nerr++; $display("FAIL arb_out_clear got %b want 0", out_valid); end
  endtask

  task automatic test_ignore_start;
    @(negedge clk);
    start = 1'b1; opcode = 2'b00;
    @(negedge clk);
    start = 1'b0;
    #1;
    nvec++;
    if ({busy, mem_rd_en} !== 2'b00) begin
      nerr++; $display("FAIL nop_start got busy=%b en=%b want 0/0", busy, mem_rd_en);
    end
    start = 1'b1; opcode = 2'b10;
    for (int p = 0; p < 8; p++) begin
      @(negedge clk);
      opcode = p[0] ? 2'b01 : 2'b11;
      #1;
      nvec++;
      if ({busy, cau_opcode, mem_rd_en, mem_addr} !== {1'b1, 2'b10, 1'b1, 10'(p)}) begin
        nerr++; $display("FAIL busy_start_fetch p=%0d got busy=%b op=%b en=%b addr=%0d", p, busy, cau_opcode, mem_rd_en, mem_addr);
      end
      @(negedge clk); #1;
      nvec++;
      if ({cau_valid, cau_data} !== {1'b1, 8'(p)}) begin
        nerr++; $display("FAIL busy_start_send p=%0d got v=%b data=%0d want 1/%0d", p, cau_valid, cau_data, p);
      end
    end
    start = 1'b0;
  endtask

  task automatic test_abort;
    int d0, x0;
    bit seen;
    seen = 1'b0;
    d0 = done_count;
    #1;
    rst = 1'b1;
    #1;
    nvec++;
    if ({busy, cau_valid, cau_sel, cau_opcode} !== 8'h00) begin
      nerr++; $display("FAIL abort_outputs got busy=%b v=%b sel=%b op=%b want zero", busy, cau_valid, cau_sel, cau_opcode);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    nvec++;
    if ({busy, 1'b0} !== 2'b00 || done_count !== d0) begin
      nerr++; $display("FAIL abort_no_done got busy=%b dones=%0d want 0/%0d", busy, done_count, d0);
    end
    x0 = xfer_count;
    start = 1'b1; opcode = 2'b01;
    @(negedge clk);
    start = 1'b0;
    #1;
    nvec++;
    if ({mem_rd_en, mem_addr} !== {1'b1, 10'd0}) begin
      nerr++; $display("FAIL abort_refetch got en=%b addr=%0d want 1/0", mem_rd_en, mem_addr);
    end
    @(negedge clk); #1;
    nvec++;
    if ({cau_valid, cau_sel, cau_data} !== {1'b1, 4'b0001, 8'd0}) begin
      nerr++; $display("FAIL abort_first_xfer got v=%b sel=%b data=%0d want 1/0001/0", cau_valid, cau_sel, cau_data);
    end
    $display("abort: restart pixel %0d sel %b", cau_data, cau_sel);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (done) begin seen = 1'b1; break; end
    end
    nvec++;
    if (!seen) begin nerr++; $display("FAIL abort_frame_done got no done want done pulse"); end
    @(negedge clk); #1;
    nvec++;
    if (done_count - d0 !== 1 || xfer_count - x0 !== 16) begin
      nerr++; $display("FAIL abort_counts got dones=%0d xfers=%0d want 1/16", done_count - d0, xfer_count - x0);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0; opcode = 2'b00;
    cau_ready = 4'b1111; cau_busy = 4'b0000;
    cau_res_valid = 4'b0000; cau_res_data = 32'h0;
    start2 = 1'b0; opcode2 = 2'b00;
    cau_ready2 = 3'b111; cau_busy2 = 3'b000;
    cau_res_valid2 = 3'b000; cau_res_data2 = 24'h0;
    test_reset();
    test_three_units();
    test_frame();
    test_stall_and_restart();
    test_arbiter();
    test_ignore_start();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
